// File: rtl/bla32_sub_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor, D = A - B - Bin, with valid/ready on both sides.
// Stage 1 resolves the low LO_W bits; stage 2 finishes the high bits from the registered borrow.

module bla32_sub_blk #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic [N-1:0] diff,
   output logic         bout
);
   logic [N-1:0] g, p;
   logic [N:0]   brw;

   assign g = ~a & b;
   assign p = ~(a ^ b);

   // Flat sum-of-products borrow into bit n: bin killed or propagated through p[n-1:0],
   // or generated at bit j and propagated through p[n-1:j+1].
   function automatic logic lookahead(input logic [N-1:0] gv, input logic [N-1:0] pv,
                                      input logic bi, input int n);
      logic t, r;
      t = bi;
      for (int k = 0; k < n; k++) t = t & pv[k];
      r = t;
      for (int j = 0; j < n; j++) begin
         t = gv[j];
         for (int k = j + 1; k < n; k++) t = t & pv[k];
         r = r | t;
      end
      return r;
   endfunction

   for (genvar i = 0; i <= N; i++) begin : g_brw
      assign brw[i] = lookahead(g, p, bin, i);
   end

   assign diff = a ^ b ^ brw[N-1:0];
   assign bout = brw[N];
endmodule

module bla32_sub_pipe #(
   parameter int WIDTH = 32,
   parameter int LO_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf,
   output logic             Zero
);
   localparam int HI_W = WIDTH - LO_W;

   logic            s1_valid, s2_valid, s2_adv, acc;
   logic [LO_W-1:0] lo_diff, s1_dlo;
   logic            lo_bout, s1_b;
   logic [HI_W-1:0] s1_ahi, s1_bhi, hi_diff;
   logic            s1_amsb, s1_bmsb, hi_bout, ovf_c;
   logic [WIDTH-1:0] full;

   assign s2_adv    = s1_valid & (~s2_valid | out_ready);
   assign in_ready  = ~s1_valid | s2_adv;
   assign acc       = in_valid & in_ready;
   assign out_valid = s2_valid;

   bla32_sub_blk #(.N(LO_W)) u_lo (
      .a(A[LO_W-1:0]), .b(B[LO_W-1:0]), .bin(Bin), .diff(lo_diff), .bout(lo_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_dlo   <= '0;
         s1_b     <= 1'b0;
         s1_ahi   <= '0;
         s1_bhi   <= '0;
         s1_amsb  <= 1'b0;
         s1_bmsb  <= 1'b0;
      end else begin
         s1_valid <= acc | (s1_valid & ~s2_adv);
         if (acc) begin
            s1_dlo  <= lo_diff;
            s1_b    <= lo_bout;
            s1_ahi  <= A[WIDTH-1:LO_W];
            s1_bhi  <= B[WIDTH-1:LO_W];
            s1_amsb <= A[WIDTH-1];
            s1_bmsb <= B[WIDTH-1];
         end
      end
   end

   bla32_sub_blk #(.N(HI_W)) u_hi (
      .a(s1_ahi), .b(s1_bhi), .bin(s1_b), .diff(hi_diff), .bout(hi_bout)
   );

   assign full  = {hi_diff, s1_dlo};
   assign ovf_c = (s1_amsb != s1_bmsb) & (full[WIDTH-1] != s1_amsb);

   // Output regs only load on s2_adv, so a stalled result holds steady.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         Diff     <= '0;
         Bout     <= 1'b0;
         Ovf      <= 1'b0;
         Zero     <= 1'b0;
      end else begin
         s2_valid <= s2_adv | (s2_valid & ~out_ready);
         if (s2_adv) begin
            Diff <= full;
            Bout <= hi_bout;
            Ovf  <= ovf_c;
            Zero <= ~|full;
         end
      end
   end
endmodule

// File: tb/tb_bla32_sub_pipe.sv
// Bench for bla32_sub_pipe: directed vector table, handshake corner sequences,
// and randomized traffic scored against an arithmetic reference.

module tb_bla32_sub_pipe;
   logic        clk, rst_n, in_valid, in_ready, Bin, out_valid, out_ready;
   logic        Bout, Ovf, Zero;
   logic [31:0] A, B, Diff;

   bla32_sub_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
      .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic        bo, ov, z;
   } res_t;

   typedef struct {
      logic [31:0] a, b;
      logic        bin;
      res_t        r;
   } vec_t;

   int   checks = 0, errors = 0, hs_cnt = 0;
   res_t q[$];
   res_t mon_e, held;
   logic prev_stall;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
      res_t   r;
      longint sa, sb, sr;
      r.d  = a - b - {31'd0, bin};
      r.bo = (longint'(a) < longint'(b) + longint'(bin));
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      sr   = sa - sb - longint'(bin);
      r.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r.z  = (r.d == 32'd0);
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_FFFF;
         4: return 32'h0001_0000;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: accepted ops queue in order, delivered results must match the head.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {29'd0, Diff, Bout, Ovf, Zero}, {29'd0, held});
         end
         if (in_valid && in_ready) q.push_back(model(A, B, Bin));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out got diff %h with nothing outstanding", Diff);
            end else begin
               mon_e = q.pop_front();
               chk("out_res", {29'd0, Diff, Bout, Ovf, Zero}, {29'd0, mon_e});
               hs_cnt++;
            end
         end
         prev_stall <= out_valid && !out_ready;
         held       <= {Diff, Bout, Ovf, Zero};
      end
   end

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain got %0d outstanding exp 0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   vec_t        vt[9];
   res_t        er;
   logic [31:0] oa[4], ob[4];
   logic        obin[4];
   int          idx, h0, n;
   logic        acc, pending;

   initial begin
      vt[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}};
      vt[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
      vt[2] = '{32'h0001_0000, 32'h0000_0000, 1'b1, '{32'h0000_FFFF, 1'b0, 1'b0, 1'b0}};
      vt[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
      vt[4] = '{32'h1234_5678, 32'h1234_5678, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
      vt[5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
      vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
      vt[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
      vt[8] = '{32'h0001_0000, 32'h0000_0001, 1'b0, '{32'h0000_FFFF, 1'b0, 1'b0, 1'b0}};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; Bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_outputs", {29'd0, Diff, Bout, Ovf, Zero}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, each checked at exactly two edges after presentation.
      for (int i = 0; i < 9; i++) begin
         A = vt[i].a; B = vt[i].b; Bin = vt[i].bin; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("vec_latency", {63'd0, out_valid}, 64'd0);
         @(posedge clk); #1;
         chk("vec_valid", {63'd0, out_valid}, 64'd1);
         chk("vec_diff", {32'd0, Diff}, {32'd0, vt[i].r.d});
         chk("vec_flags", {61'd0, Bout, Ovf, Zero}, {61'd0, vt[i].r.bo, vt[i].r.ov, vt[i].r.z});
      end
      drain();

      // Back-to-back 8 ops at full rate.
      for (int i = 0; i < 8; i++) begin
         A = rnd_op(); B = rnd_op(); Bin = 1'($urandom); in_valid = 1'b1;
         chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
         if (i >= 2) chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
      chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
      drain();

      // Backpressure: both stages fill, then in_ready drops.
      for (int i = 0; i < 4; i++) begin
         oa[i] = rnd_op(); ob[i] = rnd_op(); obin[i] = 1'($urandom);
      end
      h0 = hs_cnt; idx = 0; out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         A = oa[idx]; B = ob[idx]; Bin = obin[idx]; in_valid = 1'b1;
         #1;
         acc = in_valid & in_ready;
         if (c >= 2) chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         @(posedge clk); #1;
         if (acc) idx++;
      end
      chk("bp_accepts", 64'(idx), 64'd2);
      out_ready = 1'b1; n = 0;
      while (idx < 4 && n < 20) begin
         A = oa[idx]; B = ob[idx]; Bin = obin[idx]; in_valid = 1'b1;
         #1;
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         n++;
      end
      chk("bp_all_accepted", 64'(idx), 64'd4);
      drain();
      chk("bp_delivered", 64'(hs_cnt - h0), 64'd4);

      // Reset with two ops in flight.
      A = rnd_op(); B = rnd_op(); Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      A = rnd_op(); B = rnd_op(); Bin = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b0;
      #1;
      q.delete();
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_outputs", {29'd0, Diff, Bout, Ovf, Zero}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      A = 32'h0001_0000; B = 32'h0000_0001; Bin = 1'b1; in_valid = 1'b1;
      er = model(A, B, Bin);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_latency", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
      chk("post_rst_res", {29'd0, Diff, Bout, Ovf, Zero}, {29'd0, er});
      drain();

      // Randomized traffic with random backpressure; the source holds unaccepted operands.
      h0 = hs_cnt; idx = 0; pending = 1'b0;
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pending && $urandom_range(0, 3) != 0) begin
            A = rnd_op(); B = rnd_op(); Bin = 1'($urandom); pending = 1'b1;
         end
         in_valid = pending;
         #1;
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) begin
            pending = 1'b0;
            idx++;
         end
      end
      drain();
      chk("rand_delivered", 64'(hs_cnt - h0), 64'(idx));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
